down_counter_timer: RTL

- Loadable 12-bit down counter and timer. It is the countdown counterpart of the free-running up counter used in the lab datapath.
- Software or FSM logic loads a start value and issues start. The block counts down once per prescaled tick and reports expiry with a one-cycle done pulse.
- Optional auto-reload mode turns it into a periodic event generator, for example a display refresh or sample strobe.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/down_counter_timer.sv | 105 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths, state encoding and helpers for the down counter timer
package counter_pkg;

    localparam int COUNT_W          = 12;
    localparam int PRESCALE_W       = 16;
    localparam int DEFAULT_TICK_DIV = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_count(
        input logic [COUNT_W-1:0] value,
        input logic [COUNT_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled clock cycles down to one decrement tick every TICK_DIV cycles
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable 12-bit down counter with pause, prescaled ticks and auto-reload
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int MAX_COUNT = 4095,
    parameter int TICK_DIV  = DEFAULT_TICK_DIV
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               load,
    input  logic               start,
    input  logic               pause,
    input  logic               auto_reload,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    state_t             state;
    logic [COUNT_W-1:0] reload_q;
    logic               idle_like;
    logic               pre_en;
    logic               pre_clr;
    logic               tick;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    // The prescaler must not advance on a cycle where load or pause takes priority.
    assign pre_en    = (state == S_RUN) && !load && !pause;
    assign pre_clr   = load || (start && idle_like);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            count    <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count    <= sat_count(load_val, MAX_C);
                reload_q <= sat_count(load_val, MAX_C);
                state    <= S_IDLE;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            if (reload_q == '0) begin
                                count <= '0;
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                count <= reload_q;
                                state <= S_RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            state <= S_PAUSED;
                        end else if (tick) begin
                            if (count > 12'd1) begin
                                count <= count - 1'b1;
                            end else if (auto_reload) begin
                                count <= reload_q;
                                done  <= 1'b1;
                            end else begin
                                count <= '0;
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (start) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
